// File: rtl/ysyx_22050243_mem_arbiter.sv
// ysyx_22050243_mem_arbiter
//   Shares one memory port between the instruction fetch unit (IFU, read
//   only) and the load/store unit (LSU, read/write). Only one transaction
//   can be outstanding at a time. The LSU has priority, and a starvation
//   counter makes sure the IFU still makes progress. A fetch that is
//   flushed (taken branch) still finishes on the memory side, but its
//   response pulse is suppressed.
//
// Ports
//   clk, rst          : clock; synchronous active-high reset
//   if_req_*          : IFU fetch request (valid/addr) and ready (combinational)
//   if_flush          : squash the in-flight IFU transaction
//   if_resp_*         : registered 1-cycle fetch response pulse + instruction
//   ls_req_*          : LSU request (valid/we/addr/wdata/wmask) and ready
//   ls_resp_*         : registered 1-cycle LSU response pulse + load data
//   mem_req_*         : registered request to memory, held until mem_req_ready
//   mem_resp_*        : memory response (only used in WAIT_RESP)
//   busy              : arbiter has a transaction in flight
module ysyx_22050243_mem_arbiter #(
  parameter int STARVE_MAX = 4,
  parameter int AW         = 64
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          if_req_valid,
  input  logic [AW-1:0] if_req_addr,
  output logic          if_req_ready,
  input  logic          if_flush,
  output logic          if_resp_valid,
  output logic [31:0]   if_resp_inst,
  input  logic          ls_req_valid,
  input  logic          ls_req_we,
  input  logic [AW-1:0] ls_req_addr,
  input  logic [63:0]   ls_req_wdata,
  input  logic [7:0]    ls_req_wmask,
  output logic          ls_req_ready,
  output logic          ls_resp_valid,
  output logic [63:0]   ls_resp_rdata,
  output logic          mem_req_valid,
  output logic          mem_req_we,
  output logic [AW-1:0] mem_req_addr,
  output logic [63:0]   mem_req_wdata,
  output logic [7:0]    mem_req_wmask,
  input  logic          mem_req_ready,
  input  logic          mem_resp_valid,
  input  logic [63:0]   mem_resp_rdata,
  output logic          busy
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_WAIT = 2'd2;

  localparam logic [1:0] OWN_NONE = 2'd0;
  localparam logic [1:0] OWN_IFU  = 2'd1;
  localparam logic [1:0] OWN_LSU  = 2'd2;

  localparam int CW = $clog2(STARVE_MAX + 1);
  localparam logic [CW-1:0] STARVE_LIM = CW'(STARVE_MAX);

  logic [1:0]    state_q, state_d;
  logic [1:0]    owner_q, owner_d;
  logic [CW-1:0] starve_q, starve_d;
  logic          squash_q, squash_d;

  logic          mreq_valid_q, mreq_valid_d;
  logic          mreq_we_q, mreq_we_d;
  logic [AW-1:0] mreq_addr_q, mreq_addr_d;
  logic [63:0]   mreq_wdata_q, mreq_wdata_d;
  logic [7:0]    mreq_wmask_q, mreq_wmask_d;

  logic          if_rv_q, if_rv_d;
  logic [31:0]   if_inst_q, if_inst_d;
  logic          ls_rv_q, ls_rv_d;
  logic [63:0]   ls_rdata_q, ls_rdata_d;

  logic idle;
  logic if_win;
  logic if_flush_hit;

  assign idle   = (state_q == S_IDLE);
  // When the starvation limit is reached, the IFU wins even against a valid LSU request.
  assign if_win = if_req_valid && (!ls_req_valid || (starve_q == STARVE_LIM));

  assign if_req_ready = idle && if_win;
  assign ls_req_ready = idle && !if_win && ls_req_valid;

  // A flush only matters while the IFU owns a transaction in flight.
  assign if_flush_hit = if_flush && (owner_q == OWN_IFU) && !idle;

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    starve_d     = starve_q;
    squash_d     = squash_q;
    mreq_valid_d = mreq_valid_q;
    mreq_we_d    = mreq_we_q;
    mreq_addr_d  = mreq_addr_q;
    mreq_wdata_d = mreq_wdata_q;
    mreq_wmask_d = mreq_wmask_q;
    if_rv_d      = 1'b0;
    if_inst_d    = if_inst_q;
    ls_rv_d      = 1'b0;
    ls_rdata_d   = ls_rdata_q;

    if (if_flush_hit) squash_d = 1'b1;

    case (state_q)
      S_IDLE: begin
        if (if_req_ready) begin
          state_d      = S_REQ;
          owner_d      = OWN_IFU;
          mreq_valid_d = 1'b1;
          mreq_we_d    = 1'b0;
          mreq_addr_d  = if_req_addr;
          starve_d     = '0;
        end else if (ls_req_ready) begin
          state_d      = S_REQ;
          owner_d      = OWN_LSU;
          mreq_valid_d = 1'b1;
          mreq_we_d    = ls_req_we;
          mreq_addr_d  = ls_req_addr;
          mreq_wdata_d = ls_req_wdata;
          mreq_wmask_d = ls_req_wmask;
          if (if_req_valid && (starve_q != STARVE_LIM)) starve_d = starve_q + CW'(1);
        end
      end
      S_REQ: begin
        if (mem_req_ready) begin
          mreq_valid_d = 1'b0;
          state_d      = S_WAIT;
        end
      end
      S_WAIT: begin
        if (mem_resp_valid) begin
          state_d  = S_IDLE;
          owner_d  = OWN_NONE;
          squash_d = 1'b0;
          if (owner_q == OWN_IFU) begin
            // A flush in the same cycle as the response also suppresses the pulse.
            if_inst_d = mreq_addr_q[2] ? mem_resp_rdata[63:32] : mem_resp_rdata[31:0];
            if_rv_d   = !(squash_q || if_flush);
          end else begin
            ls_rv_d    = 1'b1;
            ls_rdata_d = mreq_we_q ? 64'd0 : mem_resp_rdata;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      owner_q      <= OWN_NONE;
      starve_q     <= '0;
      squash_q     <= 1'b0;
      mreq_valid_q <= 1'b0;
      mreq_we_q    <= 1'b0;
      mreq_addr_q  <= '0;
      mreq_wdata_q <= '0;
      mreq_wmask_q <= '0;
      if_rv_q      <= 1'b0;
      if_inst_q    <= '0;
      ls_rv_q      <= 1'b0;
      ls_rdata_q   <= '0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      starve_q     <= starve_d;
      squash_q     <= squash_d;
      mreq_valid_q <= mreq_valid_d;
      mreq_we_q    <= mreq_we_d;
      mreq_addr_q  <= mreq_addr_d;
      mreq_wdata_q <= mreq_wdata_d;
      mreq_wmask_q <= mreq_wmask_d;
      if_rv_q      <= if_rv_d;
      if_inst_q    <= if_inst_d;
      ls_rv_q      <= ls_rv_d;
      ls_rdata_q   <= ls_rdata_d;
    end
  end

  assign mem_req_valid = mreq_valid_q;
  assign mem_req_we    = mreq_we_q;
  assign mem_req_addr  = mreq_addr_q;
  assign mem_req_wdata = mreq_wdata_q;
  assign mem_req_wmask = mreq_wmask_q;
  assign if_resp_valid = if_rv_q;
  assign if_resp_inst  = if_inst_q;
  assign ls_resp_valid = ls_rv_q;
  assign ls_resp_rdata = ls_rdata_q;
  assign busy          = !idle;

endmodule

// File: tb/tb_ysyx_22050243_mem_arbiter.sv
// Bench for ysyx_22050243_mem_arbiter: random requesters and memory, checked
// every cycle against a transaction-level reference model.
module tb_ysyx_22050243_mem_arbiter;
  localparam int AW = 64;
  localparam int SM = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic          if_req_valid, if_req_ready, if_flush, if_resp_valid;
  logic [AW-1:0] if_req_addr;
  logic [31:0]   if_resp_inst;
  logic          ls_req_valid, ls_req_we, ls_req_ready, ls_resp_valid;
  logic [AW-1:0] ls_req_addr;
  logic [63:0]   ls_req_wdata, ls_resp_rdata;
  logic [7:0]    ls_req_wmask;
  logic          mem_req_valid, mem_req_we, mem_req_ready, mem_resp_valid, busy;
  logic [AW-1:0] mem_req_addr;
  logic [63:0]   mem_req_wdata, mem_resp_rdata;
  logic [7:0]    mem_req_wmask;

  ysyx_22050243_mem_arbiter #(.STARVE_MAX(SM), .AW(AW)) dut (
    .clk(clk), .rst(rst),
    .if_req_valid(if_req_valid), .if_req_addr(if_req_addr), .if_req_ready(if_req_ready),
    .if_flush(if_flush), .if_resp_valid(if_resp_valid), .if_resp_inst(if_resp_inst),
    .ls_req_valid(ls_req_valid), .ls_req_we(ls_req_we), .ls_req_addr(ls_req_addr),
    .ls_req_wdata(ls_req_wdata), .ls_req_wmask(ls_req_wmask), .ls_req_ready(ls_req_ready),
    .ls_resp_valid(ls_resp_valid), .ls_resp_rdata(ls_resp_rdata),
    .mem_req_valid(mem_req_valid), .mem_req_we(mem_req_we), .mem_req_addr(mem_req_addr),
    .mem_req_wdata(mem_req_wdata), .mem_req_wmask(mem_req_wmask), .mem_req_ready(mem_req_ready),
    .mem_resp_valid(mem_resp_valid), .mem_resp_rdata(mem_resp_rdata), .busy(busy)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model: one transaction record (pending / accepted by memory).
  bit          m_pend, m_sent, m_isif, m_we, m_sq;
  logic [63:0] m_addr, m_wdata;
  logic [7:0]  m_wmask;
  int          m_starve;
  bit          e_ifv, e_lsv;
  logic [31:0] e_inst;
  logic [63:0] e_rdata;

  // Stimulus knobs (percent, except p_rst in per-mille).
  int p_if, p_ls, p_rdy, p_flush, p_stale, p_rst, lat_max;
  bit fix_en; logic [63:0] fix_rdata; int fix_lat;

  // Requesters and memory agent.
  bit ifp, lsp, mb;
  int mcnt;

  // Event bookkeeping for directed checks.
  int cyc, n_if_gr, n_ls_gr, t_ifgr, t_ifresp;
  logic [31:0] seen_inst;

  function automatic bit pct(input int p);
    return ($urandom_range(99, 0) < p);
  endfunction

  task automatic model_reset();
    m_pend = 0; m_sent = 0; m_isif = 0; m_we = 0; m_sq = 0;
    m_addr = '0; m_wdata = '0; m_wmask = '0; m_starve = 0;
    e_ifv = 0; e_lsv = 0; e_inst = '0; e_rdata = '0;
  endtask

  // Called right after a falling edge.
  task automatic drive();
    rst = ($urandom_range(999, 0) < p_rst);
    if (!ifp && pct(p_if)) begin
      ifp = 1;
      if_req_addr = {$urandom, $urandom} & ~64'h3;
    end
    if_req_valid = ifp;
    if (!lsp && pct(p_ls)) begin
      lsp = 1;
      ls_req_we    = $urandom_range(1, 0) == 1;
      ls_req_addr  = {$urandom, $urandom} & ~64'h7;
      ls_req_wdata = {$urandom, $urandom};
      ls_req_wmask = 8'($urandom);
    end
    ls_req_valid = lsp;
    if_flush = pct(p_flush);
    mem_req_ready = !mb && pct(p_rdy);
    if (mb && mcnt == 0) begin
      mem_resp_valid = 1;
      mem_resp_rdata = fix_en ? fix_rdata : {$urandom, $urandom};
    end else begin
      mem_resp_valid = !mb && pct(p_stale);
      mem_resp_rdata = {$urandom, $urandom};
    end
  endtask

  // Check the current cycle, then advance the model across the rising edge.
  task automatic tick();
    bit ifw, eif, els, emv;
    #1;
    ifw = if_req_valid && (!ls_req_valid || m_starve == SM);
    eif = !m_pend && ifw;
    els = !m_pend && !ifw && ls_req_valid;
    emv = m_pend && !m_sent;
    chk("if_req_ready", 64'(if_req_ready), 64'(eif));
    chk("ls_req_ready", 64'(ls_req_ready), 64'(els));
    chk("mem_req_valid", 64'(mem_req_valid), 64'(emv));
    chk("mem_req_addr", mem_req_addr, m_addr);
    chk("mem_req_we", 64'(mem_req_we), 64'(m_we));
    chk("mem_req_wdata", mem_req_wdata, m_wdata);
    chk("mem_req_wmask", 64'(mem_req_wmask), 64'(m_wmask));
    chk("busy", 64'(busy), 64'(m_pend));
    chk("if_resp_valid", 64'(if_resp_valid), 64'(e_ifv));
    chk("if_resp_inst", 64'(if_resp_inst), 64'(e_inst));
    chk("ls_resp_valid", 64'(ls_resp_valid), 64'(e_lsv));
    chk("ls_resp_rdata", ls_resp_rdata, e_rdata);
    if (!rst && eif) begin n_if_gr++; t_ifgr = cyc; end
    if (!rst && els) n_ls_gr++;
    if (if_resp_valid && t_ifresp < 0) begin t_ifresp = cyc; seen_inst = if_resp_inst; end

    @(posedge clk);
    // memory agent
    if (mb) begin
      if (mcnt == 0) mb = 0; else mcnt--;
    end else if (emv && mem_req_ready && !rst) begin
      mb = 1;
      mcnt = (fix_lat >= 0) ? fix_lat : $urandom_range(lat_max, 0);
    end
    // requesters
    if (!rst && eif) ifp = 0;
    if (!rst && els) lsp = 0;
    // reference model
    if (rst) model_reset();
    else begin
      e_ifv = 0; e_lsv = 0;
      if (!m_pend) begin
        if (eif) begin
          m_pend = 1; m_sent = 0; m_isif = 1; m_we = 0; m_sq = 0;
          m_addr = if_req_addr; m_starve = 0;
        end else if (els) begin
          m_pend = 1; m_sent = 0; m_isif = 0; m_sq = 0;
          m_we = ls_req_we; m_addr = ls_req_addr; m_wdata = ls_req_wdata; m_wmask = ls_req_wmask;
          if (if_req_valid) m_starve = (m_starve < SM) ? m_starve + 1 : SM;
        end
      end else begin
        if (if_flush && m_isif) m_sq = 1;
        if (!m_sent) begin
          if (mem_req_ready) m_sent = 1;
        end else if (mem_resp_valid) begin
          m_pend = 0;
          if (m_isif) begin
            e_inst = m_addr[2] ? mem_resp_rdata[63:32] : mem_resp_rdata[31:0];
            e_ifv  = !m_sq;
          end else begin
            e_lsv   = 1;
            e_rdata = m_we ? 64'd0 : mem_resp_rdata;
          end
          m_sq = 0;
        end
      end
    end
    cyc++;
    @(negedge clk);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) begin drive(); tick(); end
  endtask

  initial begin
    rst = 1; if_req_valid = 0; if_req_addr = '0; if_flush = 0;
    ls_req_valid = 0; ls_req_we = 0; ls_req_addr = '0; ls_req_wdata = '0; ls_req_wmask = '0;
    mem_req_ready = 0; mem_resp_valid = 0; mem_resp_rdata = '0;
    ifp = 0; lsp = 0; mb = 0; mcnt = 0; cyc = 0;
    n_if_gr = 0; n_ls_gr = 0; t_ifgr = -1; t_ifresp = -1; seen_inst = '0;
    fix_en = 0; fix_rdata = '0; fix_lat = -1; lat_max = 3;
    p_if = 0; p_ls = 0; p_rdy = 0; p_flush = 0; p_stale = 0; p_rst = 1000;
    model_reset();
    @(negedge clk);
    // reset state, with a stale response present
    run(1); mem_resp_valid = 1; tick();
    p_rst = 0;

    // single IFU fetch: 0x8000_0004, response 2 cycles after accept
    p_rdy = 100; fix_lat = 1; fix_en = 1; fix_rdata = 64'hDEADBEEF_00000013;
    ifp = 1; if_req_addr = 64'h8000_0004;
    t_ifgr = -1; t_ifresp = -1;
    run(12);
    chk("fetch_latency", 64'(t_ifresp - t_ifgr), 64'd4);
    chk("fetch_inst", 64'(seen_inst), 64'hDEADBEEF);
    fix_en = 0;

    // simultaneous requests then starvation: 4 LSU grants, IFU, then 4 again
    p_if = 100; p_ls = 100; fix_lat = -1; lat_max = 2;
    for (int r = 0; r < 2; r++) begin
      n_if_gr = 0; n_ls_gr = 0;
      for (int i = 0; i < 200 && n_if_gr == 0; i++) run(1);
      chk("starve_ls_grants", 64'(n_ls_gr), 64'(SM));
      chk("starve_if_grant", 64'(n_if_gr), 64'd1);
    end

    // memory backpressure
    p_rdy = 0; run(8); p_rdy = 100; run(10);

    // reset while waiting for a response; stale response arrives afterwards
    fix_lat = 4; p_ls = 0;
    for (int i = 0; i < 100 && !(m_pend && m_sent); i++) run(1);
    chk("midop_reached_wait", 64'(m_sent), 64'd1);
    drive(); rst = 1; tick();
    run(12);
    fix_lat = -1;

    // flush-heavy phase
    p_if = 70; p_ls = 30; p_flush = 25; p_rdy = 60; lat_max = 3;
    run(400);

    // general random traffic, including stale responses and random resets
    p_if = 50; p_ls = 50; p_flush = 5; p_rdy = 70; p_stale = 10; p_rst = 4; lat_max = 4;
    run(3000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end
endmodule
